// File: rtl/sprite_compositor.sv
//------------------------------------------------------------------------------
// sprite_compositor
//
// Purpose:
//   Multi-sprite renderer for the VGA pixel path. Up to NUM_SPRITES
//   rectangular bitmaps are composed over a background colour for each active
//   pixel. Every sprite can be scaled by a power of two. Source pixels equal
//   to the TRANSPARENT colour key are not drawn. Channel 0 has the highest
//   priority. Sprite attributes are latched once per frame, so changes made
//   mid-frame only appear at the next FRAME_START.
//
//   Pipeline (one pixel per clock, 2 cycles from X/Y to RGB_OUT):
//     stage 0 : hit test and bitmap address (combinational), sent to MEM_ADDR
//     stage 1 : bitmap data returns, then opacity, priority and overlap
//     stage 2 : output registers (RGB_OUT, HIT_ID, RGB_VALID, COLLISION)
//
// Ports:
//   CLK          pixel clock
//   reset        synchronous, active-high reset
//   PIX_VALID    X_VGA/Y_VGA are inside the active area
//   X_VGA/Y_VGA  active-area column/row, 0-based
//   FRAME_START  one-cycle pulse before the first active pixel of a frame
//   SPR_EN       per-sprite enable
//   SPR_X/SPR_Y  per-sprite left/top edge, 10 bits per sprite
//   SPR_SHIFT    per-sprite scale exponent, 2 bits per sprite
//   MEM_ADDR     per-sprite bitmap read address (AW bits per sprite)
//   MEM_DATA     per-sprite bitmap data, one cycle after MEM_ADDR
//   RGB_OUT      composed pixel colour
//   RGB_VALID    PIX_VALID delayed by two cycles
//   HIT_ID       index of the drawn sprite, 7 for background
//   COLLISION    sticky overlap flag, cleared by FRAME_START
//------------------------------------------------------------------------------
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W = 40,
    parameter int SPR_H = 40,
    parameter int CW = 9,
    parameter int AW = 11,
    parameter logic [CW-1:0] TRANSPARENT = 9'h1C7,
    parameter logic [CW-1:0] BG_COLOR = 9'h000
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      PIX_VALID,
    input  logic [9:0]                X_VGA,
    input  logic [9:0]                Y_VGA,
    input  logic                      FRAME_START,
    input  logic [NUM_SPRITES-1:0]    SPR_EN,
    input  logic [10*NUM_SPRITES-1:0] SPR_X,
    input  logic [10*NUM_SPRITES-1:0] SPR_Y,
    input  logic [2*NUM_SPRITES-1:0]  SPR_SHIFT,
    output logic [AW*NUM_SPRITES-1:0] MEM_ADDR,
    input  logic [CW*NUM_SPRITES-1:0] MEM_DATA,
    output logic [CW-1:0]             RGB_OUT,
    output logic                      RGB_VALID,
    output logic [2:0]                HIT_ID,
    output logic                      COLLISION
);

    // Range arithmetic is done at this width so that a sprite placed near the
    // right or bottom edge clips instead of wrapping its far edge back to 0.
    localparam int EXW = 16;
    localparam logic [EXW-1:0] W_EXT = EXW'(SPR_W);
    localparam logic [EXW-1:0] H_EXT = EXW'(SPR_H);
    localparam logic [AW-1:0]  W_ADDR = AW'(SPR_W);

    // Frame-latched copies of the sprite attributes.
    logic [NUM_SPRITES-1:0]    r_en;
    logic [10*NUM_SPRITES-1:0] r_x;
    logic [10*NUM_SPRITES-1:0] r_y;
    logic [2*NUM_SPRITES-1:0]  r_shift;

    // Stage 0 results.
    logic [NUM_SPRITES-1:0]    w_hit;
    logic [AW*NUM_SPRITES-1:0] w_addr;

    // Stage 1 registers.
    logic [NUM_SPRITES-1:0]    r_hit1;
    logic                      r_valid1;

    // Stage 1 combinational results.
    logic [NUM_SPRITES-1:0]    w_opaque;
    logic [CW-1:0]             w_selColor;
    logic [2:0]                w_selId;
    logic                      w_seen;
    logic                      w_multi;

    // Attributes are sampled only on FRAME_START so the whole frame renders
    // with one consistent set; reset disables every sprite.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_en    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_shift <= '0;
        end else if (FRAME_START) begin
            r_en    <= SPR_EN;
            r_x     <= SPR_X;
            r_y     <= SPR_Y;
            r_shift <= SPR_SHIFT;
        end
    end

    // Per-sprite hit test and address generation. The offsets inside the
    // sprite are shifted right by the scale exponent to index the source
    // bitmap. The address is forced to 0 whenever the pixel misses, and the
    // hit is suppressed while reset is asserted so MEM_ADDR reads 0 then.
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        logic [1:0]     w_s;
        logic [EXW-1:0] w_x0;
        logic [EXW-1:0] w_y0;
        logic [EXW-1:0] w_px;
        logic [EXW-1:0] w_py;
        logic [EXW-1:0] w_xEnd;
        logic [EXW-1:0] w_yEnd;
        logic [EXW-1:0] w_dx;
        logic [EXW-1:0] w_dy;
        logic [AW-1:0]  w_col;
        logic [AW-1:0]  w_row;
        logic [AW-1:0]  w_lin;
        logic           w_inX;
        logic           w_inY;
        logic           w_hitG;

        assign w_s    = r_shift[2*g +: 2];
        assign w_x0   = EXW'(r_x[10*g +: 10]);
        assign w_y0   = EXW'(r_y[10*g +: 10]);
        assign w_px   = EXW'(X_VGA);
        assign w_py   = EXW'(Y_VGA);
        assign w_xEnd = w_x0 + (W_EXT << w_s);
        assign w_yEnd = w_y0 + (H_EXT << w_s);

        assign w_inX  = (w_px >= w_x0) && (w_px < w_xEnd);
        assign w_inY  = (w_py >= w_y0) && (w_py < w_yEnd);
        assign w_hitG = r_en[g] && PIX_VALID && !reset && w_inX && w_inY;

        // Offsets are only meaningful on a hit; misses are masked below.
        assign w_dx  = w_px - w_x0;
        assign w_dy  = w_py - w_y0;
        assign w_col = AW'(w_dx >> w_s);
        assign w_row = AW'(w_dy >> w_s);
        assign w_lin = w_row * W_ADDR + w_col;

        assign w_hit[g]              = w_hitG;
        assign w_addr[AW*g +: AW]    = w_hitG ? w_lin : '0;

        // Stage 1 opacity: a transparent source pixel counts as no hit.
        assign w_opaque[g] = r_hit1[g] && (MEM_DATA[CW*g +: CW] != TRANSPARENT);
    end

    assign MEM_ADDR = w_addr;

    // Stage 1 register: hit bits line up with the bitmap data that the
    // memories return on the following cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_hit1   <= '0;
            r_valid1 <= 1'b0;
        end else begin
            r_hit1   <= w_hit;
            r_valid1 <= PIX_VALID;
        end
    end

    // Fixed-priority select: the first opaque channel from index 0 upward
    // wins. Any further opaque channel on the same pixel marks an overlap.
    always_comb begin
        w_selColor = BG_COLOR;
        w_selId    = 3'd7;
        w_seen     = 1'b0;
        w_multi    = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (w_opaque[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end else begin
                    w_selColor = MEM_DATA[CW*i +: CW];
                    w_selId    = 3'(i);
                end
                w_seen = 1'b1;
            end
        end
    end

    // Output registers. Invalid pixels never hit, so they fall through to
    // the background colour and the background id.
    always_ff @(posedge CLK) begin
        if (reset) begin
            RGB_OUT   <= BG_COLOR;
            HIT_ID    <= 3'd7;
            RGB_VALID <= 1'b0;
        end else begin
            RGB_OUT   <= w_selColor;
            HIT_ID    <= w_selId;
            RGB_VALID <= r_valid1;
        end
    end

    // Sticky collision flag. A set in the same cycle as the FRAME_START clear
    // takes precedence so an overlap on the boundary is not lost.
    always_ff @(posedge CLK) begin
        if (reset) begin
            COLLISION <= 1'b0;
        end else if (w_multi) begin
            COLLISION <= 1'b1;
        end else if (FRAME_START) begin
            COLLISION <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
//------------------------------------------------------------------------------
// tb_sprite_compositor
//
// Purpose:
//   Directed self-checking bench for sprite_compositor with the default
//   parameters (4 sprites, 40x40 bitmaps, 9-bit colour). Each sprite's bitmap
//   memory is a synchronous-read model. Sprite i at address a returns
//   {2'b01, (a + 16*i) mod 128}, which is never the colour key and never the
//   background. The colour key is returned instead for a sprite whose
//   transparency flag is set.
//
// Ports: none (top-level bench).
//------------------------------------------------------------------------------
module tb_sprite_compositor;

    logic        CLK = 1'b0;
    logic        reset;
    logic        PIX_VALID;
    logic [9:0]  X_VGA;
    logic [9:0]  Y_VGA;
    logic        FRAME_START;
    logic [3:0]  SPR_EN;
    logic [39:0] SPR_X;
    logic [39:0] SPR_Y;
    logic [7:0]  SPR_SHIFT;
    logic [43:0] MEM_ADDR;
    logic [35:0] MEM_DATA = '0;
    logic [8:0]  RGB_OUT;
    logic        RGB_VALID;
    logic [2:0]  HIT_ID;
    logic        COLLISION;

    logic [3:0]  transp;
    int          errors = 0;
    int          checks = 0;

    sprite_compositor dut (
        .CLK        (CLK),
        .reset      (reset),
        .PIX_VALID  (PIX_VALID),
        .X_VGA      (X_VGA),
        .Y_VGA      (Y_VGA),
        .FRAME_START(FRAME_START),
        .SPR_EN     (SPR_EN),
        .SPR_X      (SPR_X),
        .SPR_Y      (SPR_Y),
        .SPR_SHIFT  (SPR_SHIFT),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .RGB_OUT    (RGB_OUT),
        .RGB_VALID  (RGB_VALID),
        .HIT_ID     (HIT_ID),
        .COLLISION  (COLLISION)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] pat(input int i, input logic [10:0] a);
        logic [10:0] s;
        s = a + 11'(16 * i);
        return {2'b01, s[6:0]};
    endfunction

    // Synchronous-read bitmap memories, one per sprite.
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            MEM_DATA[9*i +: 9] <= transp[i] ? 9'h1C7 : pat(i, MEM_ADDR[11*i +: 11]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input logic pv);
        X_VGA     = 10'(x);
        Y_VGA     = 10'(y);
        PIX_VALID = pv;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] rgb, input logic [2:0] id,
                               input logic vld);
        checkVal({tag, ".rgb"}, 64'(RGB_OUT), 64'(rgb));
        checkVal({tag, ".id"}, 64'(HIT_ID), 64'(id));
        checkVal({tag, ".valid"}, 64'(RGB_VALID), 64'(vld));
    endtask

    // One isolated pixel: present it, then check the result two edges later.
    task automatic checkPixel(input string tag, input int x, input int y, input logic pv,
                              input logic [8:0] rgb, input logic [2:0] id);
        applyStimulus(x, y, pv);
        tick();
        PIX_VALID = 1'b0;
        tick();
        checkOutput(tag, rgb, id, pv);
    endtask

    // As checkPixel, and also check the combinational address of one sprite.
    task automatic checkAddrPixel(input string tag, input int x, input int y, input int spr,
                                  input int addr, input logic [8:0] rgb, input logic [2:0] id);
        applyStimulus(x, y, 1'b1);
        #1;
        checkVal({tag, ".addr"}, 64'(MEM_ADDR[11*spr +: 11]), 64'(addr));
        @(posedge CLK);
        #1;
        PIX_VALID = 1'b0;
        tick();
        checkOutput(tag, rgb, id, 1'b1);
    endtask

    task automatic setSprite(input int i, input int x, input int y, input int s, input logic en);
        SPR_X[10*i +: 10]   = 10'(x);
        SPR_Y[10*i +: 10]   = 10'(y);
        SPR_SHIFT[2*i +: 2] = 2'(s);
        SPR_EN[i]           = en;
    endtask

    task automatic frameStart();
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
    endtask

    initial begin
        int px;
        logic [8:0] expRgb;
        logic [2:0] expId;

        reset       = 1'b1;
        PIX_VALID   = 1'b0;
        X_VGA       = '0;
        Y_VGA       = '0;
        FRAME_START = 1'b0;
        SPR_EN      = '0;
        SPR_X       = '0;
        SPR_Y       = '0;
        SPR_SHIFT   = '0;
        transp      = '0;
        tick();
        tick();
        tick();
        checkOutput("reset", 9'h000, 3'd7, 1'b0);
        checkVal("reset.coll", 64'(COLLISION), 64'd0);
        checkVal("reset.addr", 64'(MEM_ADDR), 64'd0);
        reset = 1'b0;
        tick();

        // Single sprite at (100,50), unscaled: streamed sweep across its row.
        $display("[TB] single sprite sweep");
        setSprite(0, 100, 50, 0, 1'b1);
        frameStart();
        for (int k = 0; k < 44; k++) begin
            if (k < 42) applyStimulus(99 + k, 50, 1'b1);
            else applyStimulus(0, 0, 1'b0);
            if (k >= 2) begin
                px = 99 + k - 2;
                if (px >= 100 && px <= 139) begin
                    expRgb = {2'b01, 7'(px - 100)};
                    expId  = 3'd0;
                end else begin
                    expRgb = 9'h000;
                    expId  = 3'd7;
                end
                checkOutput($sformatf("sweep x=%0d", px), expRgb, expId, 1'b1);
            end
            tick();
        end
        checkOutput("sweep tail", 9'h000, 3'd7, 1'b0);
        checkPixel("above top", 100, 49, 1'b1, 9'h000, 3'd7);
        checkAddrPixel("last row", 100, 89, 0, 1560, 9'h098, 3'd0);
        checkAddrPixel("last pixel", 139, 89, 0, 1599, 9'h0BF, 3'd0);
        checkPixel("below bottom", 100, 90, 1'b1, 9'h000, 3'd7);
        applyStimulus(100, 50, 1'b0);
        #1;
        checkVal("invalid.addr", 64'(MEM_ADDR[10:0]), 64'd0);
        checkPixel("invalid pixel", 100, 50, 1'b0, 9'h000, 3'd7);

        // Sprite 1 at (0,0) scaled by 4.
        $display("[TB] scaled sprite");
        setSprite(0, 100, 50, 0, 1'b0);
        setSprite(1, 0, 0, 2, 1'b1);
        frameStart();
        for (int yy = 0; yy < 4; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                checkAddrPixel($sformatf("scale %0d,%0d", xx, yy), xx, yy, 1, 0, 9'h090, 3'd1);
            end
        end
        checkAddrPixel("scale 4,0", 4, 0, 1, 1, 9'h091, 3'd1);
        checkAddrPixel("scale 0,4", 0, 4, 1, 40, 9'h0B8, 3'd1);
        checkAddrPixel("scale 8,8", 8, 8, 1, 82, 9'h0E2, 3'd1);
        checkAddrPixel("scale 159,0", 159, 0, 1, 39, 9'h0B7, 3'd1);
        checkAddrPixel("scale 0,159", 0, 159, 1, 1560, 9'h0A8, 3'd1);
        checkPixel("scale 160,0", 160, 0, 1'b1, 9'h000, 3'd7);
        checkPixel("scale 0,160", 0, 160, 1'b1, 9'h000, 3'd7);

        // Sprites 0 and 2 fully overlapped at (300,200).
        $display("[TB] overlap and collision");
        setSprite(1, 0, 0, 2, 1'b0);
        setSprite(0, 300, 200, 0, 1'b1);
        setSprite(2, 300, 200, 0, 1'b1);
        frameStart();
        checkVal("coll idle", 64'(COLLISION), 64'd0);
        checkPixel("left of overlap", 299, 200, 1'b1, 9'h000, 3'd7);
        checkVal("coll no overlap", 64'(COLLISION), 64'd0);
        applyStimulus(305, 203, 1'b1);
        tick();
        PIX_VALID = 1'b0;
        checkVal("coll +1", 64'(COLLISION), 64'd0);
        tick();
        checkVal("coll +2", 64'(COLLISION), 64'd1);
        checkOutput("overlap", 9'h0FD, 3'd0, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        checkVal("coll sticky", 64'(COLLISION), 64'd1);
        frameStart();
        checkVal("coll cleared", 64'(COLLISION), 64'd0);
        applyStimulus(300, 200, 1'b1);
        tick();
        PIX_VALID   = 1'b0;
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        checkVal("coll set wins", 64'(COLLISION), 64'd1);
        checkOutput("overlap corner", 9'h080, 3'd0, 1'b1);

        // Reset in the middle of a frame with a pixel in flight.
        $display("[TB] reset mid-frame");
        applyStimulus(300, 200, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("mid reset", 9'h000, 3'd7, 1'b0);
        checkVal("mid reset.coll", 64'(COLLISION), 64'd0);
        checkVal("mid reset.addr", 64'(MEM_ADDR), 64'd0);
        reset = 1'b0;
        checkPixel("after reset", 300, 200, 1'b1, 9'h000, 3'd7);
        frameStart();
        checkPixel("after reset+frame", 300, 200, 1'b1, 9'h080, 3'd0);

        // Sprite 0 bitmap fully transparent: sprite 2 shows through.
        $display("[TB] transparency");
        transp[0] = 1'b1;
        frameStart();
        checkPixel("transp 305,203", 305, 203, 1'b1, 9'h09D, 3'd2);
        checkPixel("transp 300,200", 300, 200, 1'b1, 9'h0A0, 3'd2);
        checkVal("transp coll", 64'(COLLISION), 64'd0);

        // Attribute shadowing and right-edge clipping.
        $display("[TB] shadowing and clipping");
        transp[0] = 1'b0;
        setSprite(2, 300, 200, 0, 1'b0);
        setSprite(0, 100, 50, 0, 1'b1);
        setSprite(3, 1000, 0, 0, 1'b1);
        frameStart();
        checkPixel("old pos", 100, 50, 1'b1, 9'h080, 3'd0);
        setSprite(0, 200, 50, 0, 1'b1);
        checkPixel("old pos held", 100, 50, 1'b1, 9'h080, 3'd0);
        checkPixel("new pos early", 200, 50, 1'b1, 9'h000, 3'd7);
        frameStart();
        checkPixel("new pos", 200, 50, 1'b1, 9'h080, 3'd0);
        checkPixel("old pos gone", 100, 50, 1'b1, 9'h000, 3'd7);
        checkPixel("clip 5,0", 5, 0, 1'b1, 9'h000, 3'd7);
        checkPixel("clip 15,0", 15, 0, 1'b1, 9'h000, 3'd7);
        checkPixel("clip 639,0", 639, 0, 1'b1, 9'h000, 3'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
Parametrised multi-sprite renderer for the VGA path. Composes up to NUM_SPRITES rectangular bitmaps onto the active display area. Supports per-sprite power-of-two scaling, colour-key transparency, fixed priority and frame-latched sprite attributes. Each sprite has its own synchronous bitmap memory, read through a dedicated address/data port. The block sits between the VGA timing generator, which supplies the active-area X/Y, and the DAC output register.

Parameters:
NUM_SPRITES, 4, number of sprite channels (1..8); channel 0 has the highest priority
SPR_W, 40, bitmap width in source pixels
SPR_H, 40, bitmap height in source pixels
CW, 9, colour word width (3R,3G,3B, MSB first)
AW, 11, bitmap address width; must satisfy 2^AW >= SPR_W*SPR_H
TRANSPARENT, 9'h1C7, colour key; source pixels with this value are not drawn
BG_COLOR, 9'h000, colour output where no opaque sprite pixel exists

Ports:
CLK  in  1  pixel clock
reset  in  1  synchronous, active-high reset
PIX_VALID  in  1  high while X_VGA/Y_VGA are inside the active area
X_VGA  in  10  active-area column, 0-based
Y_VGA  in  10  active-area row, 0-based
FRAME_START  in  1  one-cycle pulse before the first active pixel of a frame
SPR_EN  in  NUM_SPRITES  per-sprite enable
SPR_X  in  10*NUM_SPRITES  sprite left edge; sprite i occupies bits [10i+9:10i]
SPR_Y  in  10*NUM_SPRITES  sprite top edge
SPR_SHIFT  in  2*NUM_SPRITES  scale exponent s; scale factor = 2^s (1,2,4,8)
MEM_ADDR  out  AW*NUM_SPRITES  bitmap read address per sprite
MEM_DATA  in  CW*NUM_SPRITES  bitmap data, valid exactly 1 cycle after MEM_ADDR
RGB_OUT  out  CW  composed pixel colour
RGB_VALID  out  1  PIX_VALID delayed by 2 cycles
HIT_ID  out  3  index of the drawn sprite; 7 when the background is shown
COLLISION  out  1  sticky flag: two or more opaque sprite pixels have overlapped in this frame

Behaviour:
- Reset (synchronous, active-high): all shadow registers are cleared, so every sprite is disabled. Output values during reset: RGB_OUT=BG_COLOR, RGB_VALID=0, HIT_ID=7, COLLISION=0, MEM_ADDR=0. All pipeline valid bits are cleared. Asserting reset mid-frame drops all in-flight pixels.
- Shadowing: on a FRAME_START cycle, SPR_EN, SPR_X, SPR_Y and SPR_SHIFT are copied into shadow registers. All rendering uses only the shadow values, so attribute changes mid-frame take effect at the next FRAME_START.
- Stage 0 (combinational from X_VGA/Y_VGA, registered at the clock edge):
  - Hit test for sprite i: en_i && PIX_VALID && X_i <= x < X_i + (SPR_W<<s_i) && Y_i <= y < Y_i + (SPR_H<<s_i).
  - Both bounds are half-open. The sums are computed at 11+ bits so sprites near the right or bottom edge clip without wrap-around.
  - Address: ((y-Y_i)>>s_i)*SPR_W + ((x-X_i)>>s_i). This is driven on MEM_ADDR_i and is 0 when there is no hit.
  - Hit bits and PIX_VALID are registered into stage 1.
- Stage 1: MEM_DATA_i arrives. opaque_i = hit_i && (MEM_DATA_i != TRANSPARENT). opaque bits and data are registered into stage 2.
- Stage 2 (output registers):
  - RGB_OUT = data of the lowest-index opaque sprite, else BG_COLOR.
  - HIT_ID = that sprite's index, else 7.
  - RGB_VALID = delayed PIX_VALID.
- Latency: exactly 2 CLK cycles from an X_VGA/Y_VGA sample to the matching RGB_OUT. Throughput is one pixel per clock with no stalls.
- PIX_VALID=0 at the input gives RGB_OUT=BG_COLOR and HIT_ID=7 two cycles later, and that pixel is not evaluated for collision.
- COLLISION:
  - Set when 2 or more opaque bits are high in stage 2.
  - Cleared on FRAME_START.
  - If a clear and a set occur in the same cycle, the set wins.
- Transparent pixels never produce a hit, a collision or an occluding pixel; a lower-priority opaque sprite shows through them.
- Scale examples: shift 3 with SPR_W=40 covers 320 screen columns. A sprite with X=0 and shift 0 starts at column 0.

Test Plan:
1. Reset mid-frame with sprite 0 on screen -> RGB_OUT=BG_COLOR, RGB_VALID=0, COLLISION=0 on the following cycle; sprite not drawn until the next FRAME_START after reset release.
2. Sprite 0 at (100,50), shift 0, bitmap holds addr-dependent colours; sweep x=99..140 at y=50 -> RGB_OUT valid 2 cycles later. Columns 100..139 show bitmap[0..39]. Columns 99 and 140 show BG, HIT_ID=7.
3. Sprite 1 at (0,0), shift 2 -> pixels (0..3,0..3) all read address 0; pixel (4,0) reads address 1; pixel (0,4) reads address 40; pixel (160,0) shows BG.
4. Sprites 0 and 2 fully overlapped, both opaque -> RGB_OUT from sprite 0, HIT_ID=0, COLLISION rises 2 cycles after the first overlap pixel. COLLISION stays high until FRAME_START, then reads 0.
5. Same overlap with sprite 0 bitmap all TRANSPARENT -> sprite 2 colour shown, HIT_ID=2, COLLISION stays 0.
6. Change SPR_X[0] from 100 to 200 mid-frame -> rendering stays at 100 for the rest of the frame and moves to 200 after FRAME_START. Sprite at X=1000 (clipped) is never drawn.
